bus_slave_port: RTL
===================

Name: bus_slave_port

Overview:
Serial-bus responder at each slave end of the two-master/three-slave bus. It receives the serialized address, mode and write data forwarded by the arbiter/decoder once a master's transaction has been decoded to this slave. It performs the access on a local synchronous memory. For reads, it serializes the read data back onto the bus.

Parameters:
ADDR_W, 12, local address bits (bus address bits [11:0]; bits [13:12] select the slave upstream)
DATA_W, 8, data word width
MEM_DEPTH, 4096, local memory words; power of two, at most 2^ADDR_W
WAIT_CYCLES, 4, wait states inserted before each memory access; used only with SLAVE_WAIT_EN

Ports:
clk  input  1  single clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset
sel  input  1  this slave is selected by the address decoder
bus_valid  input  1  bus_wbit holds a valid serial bit this cycle
bus_mode  input  1  1 = read, 0 = write; sampled with address bit 0 only
bus_wbit  input  1  serial address bits, then write-data bits, LSB first
s_ready  output  1  slave idle and able to accept a new transaction
s_rvalid  output  1  s_rbit holds a valid read-data bit
s_rbit  output  1  serial read data, LSB first
s_done  output  1  one-cycle pulse when the transaction completes

Behaviour:
- Reset (asynchronous, reset=0): state=IDLE, s_rvalid=0, s_rbit=0, s_done=0, counters and shift registers cleared. Memory contents are not reset.
- s_ready = (state==IDLE), driven combinationally, so it reads 1 during reset.
- States: IDLE, ADDR, DATA_IN, WAIT, MEM_WR, RD1, RD2, DATA_OUT, DONE.
- IDLE: on sel&&bus_valid, capture address bit 0, latch bus_mode, set bit count=1, go to ADDR. Otherwise stay in IDLE.
- ADDR: shift in one bit per cycle when bus_valid=1. bus_valid=0 stalls with state and count held. After ADDR_W bits: write goes to DATA_IN, read goes to RD1.
- DATA_IN: shift in DATA_W bits; bus_valid=0 stalls. After the last bit, go to MEM_WR.
- MEM_WR: one cycle, mem[addr mod MEM_DEPTH] <= data, then DONE.
- RD1: present the read address to memory. RD2: load the memory output into the shift register. Then go to DATA_OUT.
- DATA_OUT: exactly DATA_W cycles with s_rvalid=1 and s_rbit=shreg[0], shifting right each cycle. There is no backpressure. Then DONE.
- DONE: s_done=1 for one cycle, then IDLE. s_rvalid=0 outside DATA_OUT.
- Abort: sel=0 while in ADDR or DATA_IN goes to IDLE next cycle. No memory write, no s_done. sel is ignored from MEM_WR/RD1 onward.
- Address wrap: memory index = addr[log2(MEM_DEPTH)-1:0]. Upper local bits are ignored.
- Timing with no stalls, cycle 0 = IDLE sample:
  - Write: address cycles 0-11, data cycles 12-19, MEM_WR cycle 20, s_done cycle 21.
  - Read: address cycles 0-11, RD1 cycle 12, RD2 cycle 13, s_rvalid cycles 14-21, s_done cycle 22.
- Back-to-back: a new transaction is accepted in the IDLE cycle immediately after DONE.

Optional Feature:
SLAVE_WAIT_EN
- Defined: the WAIT state holds for WAIT_CYCLES cycles before MEM_WR (write) or RD1 (read), emulating a slow slave. s_ready stays 0, and completion shifts later by WAIT_CYCLES. A sel drop during WAIT is ignored.
- Undefined: the WAIT state and its counter are not built, and WAIT_CYCLES is unused.

Decomposition:
- Shared package bus_pkg holds:
  - ADDR_W, DATA_W, the 14-bit bus address width and slave-ID field position [13:12];
  - MODE_READ/MODE_WRITE constants;
  - the slave state encoding.
- One sub-module, slave_bram: single-port synchronous RAM, DATA_W x MEM_DEPTH, 1-cycle read latency, write-enable port. Instantiated once.

Test Plan:
1. Write data 101 to local addr 1001, bus_valid continuous -> s_done at cycle 21; a later read returns 101.
2. Read addr 1001 after step 1 -> s_rvalid cycles 14-21, s_rbit = 1,0,1,0,0,1,1,0; s_done at cycle 22.
3. Write 102 to addr 1001 with bus_valid=0 for 3 cycles after address bit 4 -> s_done at cycle 24; readback returns 102.
4. sel dropped after 5 address bits of a write of 55 to addr 7 -> IDLE next cycle, s_ready=1, no s_done; mem[7] unchanged.
5. Reset asserted during DATA_OUT -> s_rvalid=0 and s_done=0 immediately, s_ready=1; the next full write/read completes normally.
6. SLAVE_WAIT_EN defined, WAIT_CYCLES=4: write addr 1001 -> s_done at cycle 25; read -> s_done at cycle 26.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared definitions for the two-master/three-slave serial bus.
// Holds the local address and data widths, the full bus address layout
// (14 bits, slave-ID field in [13:12]), the mode encoding and the slave
// port state encoding.
package bus_pkg;

    localparam int unsigned ADDR_W       = 12;
    localparam int unsigned DATA_W       = 8;
    localparam int unsigned BUS_ADDR_W   = 14;
    localparam int unsigned SLAVE_ID_MSB = 13;
    localparam int unsigned SLAVE_ID_LSB = 12;

    localparam logic MODE_READ  = 1'b1;
    localparam logic MODE_WRITE = 1'b0;

    typedef enum logic [3:0] {
        StIdle,
        StAddr,
        StDataIn,
        StWait,
        StMemWr,
        StRd1,
        StRd2,
        StDataOut,
        StDone
    } slave_state_e;

endpackage

// File: rtl/slave_bram.sv
// Single-port synchronous RAM, DATA_W x MEM_DEPTH, one-cycle read latency.
// Ports:
//   clk   - clock
//   we    - write enable, writes wdata to mem[addr] on the rising edge
//   addr  - word index
//   wdata - write data
//   rdata - registered read data of mem[addr] from the previous cycle
// Contents are not reset.
module slave_bram #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned MEM_DEPTH = 4096,
    parameter int unsigned IDX_W     = 12
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [MEM_DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
        rdata_q <= mem_q[addr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/bus_slave_port.sv
// Serial-bus slave responder. Shifts in a serial address (LSB first, mode
// captured with bit 0), then write data for writes, performs the access on
// a local synchronous RAM and serializes read data back out LSB first.
// Ports:
//   clk, reset (async, active low)
//   sel       - slave selected by the decoder; drop aborts address/data phase
//   bus_valid - bus_wbit valid this cycle (0 stalls the shift phases)
//   bus_mode  - 1 read / 0 write, sampled with address bit 0
//   bus_wbit  - serial address then write-data bits
//   s_ready   - idle, can accept a transaction (combinational)
//   s_rvalid  - s_rbit carries a read-data bit
//   s_rbit    - serial read data
//   s_done    - one-cycle completion pulse
// Optional feature macro: SLAVE_WAIT_EN inserts WAIT_CYCLES wait states
// before each memory access.
module bus_slave_port #(
    parameter int unsigned ADDR_W      = bus_pkg::ADDR_W,
    parameter int unsigned DATA_W      = bus_pkg::DATA_W,
    parameter int unsigned MEM_DEPTH   = 4096,
    parameter int unsigned WAIT_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic sel,
    input  logic bus_valid,
    input  logic bus_mode,
    input  logic bus_wbit,
    output logic s_ready,
    output logic s_rvalid,
    output logic s_rbit,
    output logic s_done
);

    import bus_pkg::*;

    localparam int unsigned IdxW = $clog2(MEM_DEPTH);
    localparam int unsigned CntW = $clog2(((ADDR_W > DATA_W) ? ADDR_W : DATA_W) + 1);
    localparam logic [CntW-1:0] AddrLast = CntW'(ADDR_W - 1);
    localparam logic [CntW-1:0] DataLast = CntW'(DATA_W - 1);

    slave_state_e      state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic              mode_q, mode_d;
    logic              s_rvalid_q, s_rvalid_d;
    logic              s_rbit_q, s_rbit_d;
    logic              s_done_q, s_done_d;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;
    slave_state_e      after_addr_rd, after_data_wr;

`ifdef SLAVE_WAIT_EN
    localparam int unsigned WaitW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [WaitW-1:0] WaitLast = WaitW'(WAIT_CYCLES - 1);
    logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
    assign after_addr_rd = StWait;
    assign after_data_wr = StWait;
`else
    assign after_addr_rd = StRd1;
    assign after_data_wr = StMemWr;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        shreg_d = shreg_q;
        mode_d  = mode_q;
        mem_we  = 1'b0;
`ifdef SLAVE_WAIT_EN
        wait_cnt_d = wait_cnt_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (sel && bus_valid) begin
                    addr_d  = {bus_wbit, addr_q[ADDR_W-1:1]};
                    mode_d  = bus_mode;
                    cnt_d   = CntW'(1);
                    state_d = StAddr;
                end
            end
            StAddr: begin
                if (!sel) begin
                    state_d = StIdle;
                end else if (bus_valid) begin
                    // Shift right so bit 0 ends up at the LSB after ADDR_W bits.
                    addr_d = {bus_wbit, addr_q[ADDR_W-1:1]};
                    if (cnt_q == AddrLast) begin
                        cnt_d   = '0;
                        state_d = (mode_q == MODE_READ) ? after_addr_rd : StDataIn;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StDataIn: begin
                if (!sel) begin
                    state_d = StIdle;
                end else if (bus_valid) begin
                    shreg_d = {bus_wbit, shreg_q[DATA_W-1:1]};
                    if (cnt_q == DataLast) begin
                        cnt_d   = '0;
                        state_d = after_data_wr;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StWait: begin
`ifdef SLAVE_WAIT_EN
                if (wait_cnt_q == WaitLast) begin
                    wait_cnt_d = '0;
                    state_d    = (mode_q == MODE_READ) ? StRd1 : StMemWr;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
`else
                state_d = StIdle;
`endif
            end
            StMemWr: begin
                mem_we  = 1'b1;
                state_d = StDone;
            end
            // RAM address is addr_q throughout; RD1 covers the read latency.
            StRd1: state_d = StRd2;
            StRd2: begin
                shreg_d = mem_rdata;
                cnt_d   = '0;
                state_d = StDataOut;
            end
            StDataOut: begin
                shreg_d = {1'b0, shreg_q[DATA_W-1:1]};
                if (cnt_q == DataLast) begin
                    cnt_d   = '0;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // Outputs are registered from the next state so they align with it.
        s_rvalid_d = (state_d == StDataOut);
        s_rbit_d   = (state_d == StDataOut) && shreg_d[0];
        s_done_d   = (state_d == StDone);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            addr_q     <= '0;
            shreg_q    <= '0;
            mode_q     <= MODE_WRITE;
            s_rvalid_q <= 1'b0;
            s_rbit_q   <= 1'b0;
            s_done_q   <= 1'b0;
`ifdef SLAVE_WAIT_EN
            wait_cnt_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            shreg_q    <= shreg_d;
            mode_q     <= mode_d;
            s_rvalid_q <= s_rvalid_d;
            s_rbit_q   <= s_rbit_d;
            s_done_q   <= s_done_d;
`ifdef SLAVE_WAIT_EN
            wait_cnt_q <= wait_cnt_d;
`endif
        end
    end

    slave_bram #(
        .DATA_W    (DATA_W),
        .MEM_DEPTH (MEM_DEPTH),
        .IDX_W     (IdxW)
    ) u_bram (
        .clk   (clk),
        .we    (mem_we),
        .addr  (addr_q[IdxW-1:0]),
        .wdata (shreg_q),
        .rdata (mem_rdata)
    );

    assign s_ready  = (state_q == StIdle);
    assign s_rvalid = s_rvalid_q;
    assign s_rbit   = s_rbit_q;
    assign s_done   = s_done_q;

    // Upper address bits beyond the RAM index are ignored by design.
    logic unused_bits;
    assign unused_bits = ^{addr_q, WAIT_CYCLES};

endmodule
